// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Synchronises the clock-generator lock flags and holds every downstream
//   reset domain in reset until all locks have stayed asserted long enough.
//   It then releases the domains one at a time in index order. Any lock loss
//   or software request while releasing or running reasserts all domains.
//
// Ports
//   clock              sole clock, rising edge
//   reset              synchronous, active-high
//   io_locked          asynchronous lock flags, 1 = locked
//   io_soft_reset      synchronous request to restart the sequence
//   io_resets          active-high domain resets, bit 0 released first
//   io_ready           1 while all domains are released (RUN)
//   io_lock_lost_count saturating count of lock-loss events
//   io_state           0 HOLD, 1 WAIT_LOCK, 2 RELEASE, 3 RUN
module reset_sequencer #(
  parameter int unsigned NUM_LOCKS          = 3,
  parameter int unsigned NUM_OUTPUTS        = 4,
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned MIN_ASSERT_CYCLES  = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_DELAY_CYCLES = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_LOCKS-1:0]   io_locked,
  input  logic                   io_soft_reset,
  output logic [NUM_OUTPUTS-1:0] io_resets,
  output logic                   io_ready,
  output logic [7:0]             io_lock_lost_count,
  output logic [1:0]             io_state
);

  localparam int unsigned MAX_AB  = (MIN_ASSERT_CYCLES > LOCK_STABLE_CYCLES) ?
                                    MIN_ASSERT_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > STAGE_DELAY_CYCLES) ?
                                    MAX_AB : STAGE_DELAY_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD      = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                         state_q;
  logic   [CNT_W-1:0]             cnt_q;
  logic   [NUM_OUTPUTS-1:0]       resets_q;
  logic                           ready_q;
  logic   [7:0]                   lost_q;
  logic   [SYNC_STAGES-1:0][NUM_LOCKS-1:0] sync_q;

  logic locked_all;
  logic active;
  logic abort;

  // Lock synchroniser: stage 0 samples the asynchronous flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], io_locked};
    end
  end

  assign locked_all = &sync_q[SYNC_STAGES-1];
  assign active     = (state_q == S_RELEASE) || (state_q == S_RUN);
  assign abort      = active && (!locked_all || io_soft_reset);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      resets_q <= '1;
      ready_q  <= 1'b0;
      lost_q   <= '0;
    end else if (abort) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      resets_q <= '1;
      ready_q  <= 1'b0;
      // A lock drop coinciding with a soft request is still counted once.
      if (!locked_all && (lost_q != 8'hFF)) begin
        lost_q <= lost_q + 8'd1;
      end
    end else begin
      unique case (state_q)
        S_HOLD: begin
          resets_q <= '1;
          ready_q  <= 1'b0;
          if (io_soft_reset) begin
            cnt_q <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (io_soft_reset) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
          end else if (!locked_all) begin
            cnt_q <= '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_q  <= S_RELEASE;
            cnt_q    <= '0;
            // Bit 0 is already released in the first RELEASE cycle.
            resets_q <= ~NUM_OUTPUTS'(1);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          // The thermometer itself tracks progress: shifting in zeros releases
          // the next bit, and once it is all zero one more stage delay
          // leads into RUN.
          if (cnt_q == STAGE_LAST) begin
            cnt_q <= '0;
            if (resets_q == '0) begin
              state_q <= S_RUN;
              ready_q <= 1'b1;
            end else begin
              resets_q <= resets_q << 1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          resets_q <= '0;
          ready_q  <= 1'b1;
        end
        default: begin
          state_q <= S_HOLD;
        end
      endcase
    end
  end

  assign io_resets          = resets_q;
  assign io_ready           = ready_q;
  assign io_lock_lost_count = lost_q;
  assign io_state           = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  logic       clock;
  logic       reset;
  logic [2:0] io_locked;
  logic       io_soft_reset;
  logic [3:0] io_resets;
  logic       io_ready;
  logic [7:0] io_lock_lost_count;
  logic [1:0] io_state;

  int checks;
  int errors;

  reset_sequencer #(
    .NUM_LOCKS         (3),
    .NUM_OUTPUTS       (4),
    .SYNC_STAGES       (2),
    .MIN_ASSERT_CYCLES (4),
    .LOCK_STABLE_CYCLES(8),
    .STAGE_DELAY_CYCLES(4)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .io_locked         (io_locked),
    .io_soft_reset     (io_soft_reset),
    .io_resets         (io_resets),
    .io_ready          (io_ready),
    .io_lock_lost_count(io_lock_lost_count),
    .io_state          (io_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves reset low right after the reset edge; the next tick is cycle 1.
  task automatic do_reset();
    io_locked     = 3'b111;
    io_soft_reset = 1'b0;
    reset         = 1'b1;
    ticks(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    io_locked     = 3'b111;
    io_soft_reset = 1'b0;
    reset         = 1'b1;
    ticks(2);
    checks++;
    if ({io_state, io_resets, io_ready, io_lock_lost_count} !== {2'd0, 4'b1111, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_values got st=%0d rs=%b rdy=%b cnt=%0d want st=0 rs=1111 rdy=0 cnt=0",
               io_state, io_resets, io_ready, io_lock_lost_count);
    end
  endtask

  task automatic test_powerup();
    logic [1:0] es;
    logic [3:0] er;
    logic       ey;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k < 4)       begin es = 2'd0; er = 4'b1111; ey = 1'b0; end
      else if (k < 12) begin es = 2'd1; er = 4'b1111; ey = 1'b0; end
      else if (k < 16) begin es = 2'd2; er = 4'b1110; ey = 1'b0; end
      else if (k < 20) begin es = 2'd2; er = 4'b1100; ey = 1'b0; end
      else if (k < 24) begin es = 2'd2; er = 4'b1000; ey = 1'b0; end
      else if (k < 28) begin es = 2'd2; er = 4'b0000; ey = 1'b0; end
      else             begin es = 2'd3; er = 4'b0000; ey = 1'b1; end
      checks++;
      if ({io_state, io_resets, io_ready} !== {es, er, ey}) begin
        errors++;
        $display("FAIL powerup_c%0d got st=%0d rs=%b rdy=%b want st=%0d rs=%b rdy=%b",
                 k, io_state, io_resets, io_ready, es, er, ey);
      end
    end
    checks++;
    if (io_lock_lost_count !== 8'd0) begin
      errors++;
      $display("FAIL powerup_count got %0d want 0", io_lock_lost_count);
    end
  endtask

  task automatic test_wait_glitch();
    do_reset();
    ticks(7);
    io_locked = 3'b101;
    tick();
    io_locked = 3'b111;
    ticks(9);
    checks++;
    if ({io_state, io_resets} !== {2'd1, 4'b1111}) begin
      errors++;
      $display("FAIL glitch_c17 got st=%0d rs=%b want st=1 rs=1111", io_state, io_resets);
    end
    tick();
    checks++;
    if ({io_state, io_resets} !== {2'd2, 4'b1110}) begin
      errors++;
      $display("FAIL glitch_c18 got st=%0d rs=%b want st=2 rs=1110", io_state, io_resets);
    end
    ticks(16);
    checks++;
    if ({io_state, io_ready, io_lock_lost_count} !== {2'd3, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL glitch_run got st=%0d rdy=%b cnt=%0d want st=3 rdy=1 cnt=0",
               io_state, io_ready, io_lock_lost_count);
    end
  endtask

  task automatic test_lock_loss_run();
    do_reset();
    ticks(28);
    io_locked = 3'b011;
    ticks(2);
    checks++;
    if ({io_state, io_resets, io_ready} !== {2'd3, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL loss_still_run got st=%0d rs=%b rdy=%b want st=3 rs=0000 rdy=1",
               io_state, io_resets, io_ready);
    end
    tick();
    checks++;
    if ({io_state, io_resets, io_ready, io_lock_lost_count} !== {2'd0, 4'b1111, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL loss_abort got st=%0d rs=%b rdy=%b cnt=%0d want st=0 rs=1111 rdy=0 cnt=1",
               io_state, io_resets, io_ready, io_lock_lost_count);
    end
    io_locked = 3'b111;
    ticks(11);
    checks++;
    if ({io_state, io_resets} !== {2'd1, 4'b1111}) begin
      errors++;
      $display("FAIL loss_rewait got st=%0d rs=%b want st=1 rs=1111", io_state, io_resets);
    end
    tick();
    checks++;
    if ({io_state, io_resets} !== {2'd2, 4'b1110}) begin
      errors++;
      $display("FAIL loss_rerelease got st=%0d rs=%b want st=2 rs=1110", io_state, io_resets);
    end
    ticks(16);
    checks++;
    if ({io_state, io_ready, io_lock_lost_count} !== {2'd3, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL loss_rerun got st=%0d rdy=%b cnt=%0d want st=3 rdy=1 cnt=1",
               io_state, io_ready, io_lock_lost_count);
    end
  endtask

  task automatic test_soft_reset();
    do_reset();
    ticks(28);
    io_soft_reset = 1'b1;
    tick();
    io_soft_reset = 1'b0;
    checks++;
    if ({io_state, io_resets, io_ready} !== {2'd0, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL soft_abort got st=%0d rs=%b rdy=%b want st=0 rs=1111 rdy=0",
               io_state, io_resets, io_ready);
    end
    tick();
    io_soft_reset = 1'b1;
    tick();
    io_soft_reset = 1'b0;
    ticks(3);
    checks++;
    if (io_state !== 2'd0) begin
      errors++;
      $display("FAIL soft_hold_extended got st=%0d want 0", io_state);
    end
    tick();
    checks++;
    if ({io_state, io_lock_lost_count} !== {2'd1, 8'd0}) begin
      errors++;
      $display("FAIL soft_to_wait got st=%0d cnt=%0d want st=1 cnt=0", io_state, io_lock_lost_count);
    end
  endtask

  task automatic test_soft_and_drop();
    do_reset();
    ticks(12);
    io_locked = 3'b110;
    ticks(2);
    checks++;
    if ({io_state, io_resets} !== {2'd2, 4'b1110}) begin
      errors++;
      $display("FAIL both_pre got st=%0d rs=%b want st=2 rs=1110", io_state, io_resets);
    end
    io_soft_reset = 1'b1;
    tick();
    io_soft_reset = 1'b0;
    io_locked     = 3'b111;
    checks++;
    if ({io_state, io_resets, io_lock_lost_count} !== {2'd0, 4'b1111, 8'd1}) begin
      errors++;
      $display("FAIL both_abort got st=%0d rs=%b cnt=%0d want st=0 rs=1111 cnt=1",
               io_state, io_resets, io_lock_lost_count);
    end
    ticks(5);
    checks++;
    if (io_lock_lost_count !== 8'd1) begin
      errors++;
      $display("FAIL both_count_stable got %0d want 1", io_lock_lost_count);
    end
  endtask

  task automatic test_saturation();
    int n;
    do_reset();
    for (int ev = 0; ev < 300; ev++) begin
      n = 0;
      while (io_state !== 2'd2 && n < 200) begin
        tick();
        n++;
      end
      if (n >= 200) begin
        checks++;
        errors++;
        $display("FAIL sat_wait_release got timeout want st=2 at event %0d", ev);
        break;
      end
      io_locked = 3'b000;
      n = 0;
      while (io_state !== 2'd0 && n < 20) begin
        tick();
        n++;
      end
      io_locked = 3'b111;
      if (n >= 20) begin
        checks++;
        errors++;
        $display("FAIL sat_wait_hold got timeout want st=0 at event %0d", ev);
        break;
      end
      if (ev == 0 || ev == 253 || ev == 254) begin
        checks++;
        if (io_lock_lost_count !== 8'(ev + 1)) begin
          errors++;
          $display("FAIL sat_count_ev%0d got %0d want %0d", ev, io_lock_lost_count, ev + 1);
        end
      end
    end
    checks++;
    if (io_lock_lost_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_final got %0d want 255", io_lock_lost_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ticks(28);
    io_locked = 3'b011;
    ticks(3);
    io_locked = 3'b111;
    ticks(16);
    checks++;
    if ({io_resets, io_lock_lost_count} !== {4'b1100, 8'd1}) begin
      errors++;
      $display("FAIL mid_pre got rs=%b cnt=%0d want rs=1100 cnt=1", io_resets, io_lock_lost_count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({io_state, io_resets, io_ready, io_lock_lost_count} !== {2'd0, 4'b1111, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL mid_reset got st=%0d rs=%b rdy=%b cnt=%0d want st=0 rs=1111 rdy=0 cnt=0",
               io_state, io_resets, io_ready, io_lock_lost_count);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    io_locked     = 3'b111;
    io_soft_reset = 1'b0;
    test_reset();
    test_powerup();
    test_wait_glitch();
    test_lock_loss_run();
    test_soft_reset();
    test_soft_and_drop();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
